// File: rtl/ntt_layer_scheduler.sv
// ntt_layer_scheduler
// Drives a 256-point in-place Kyber forward NTT through one shared pipelined
// butterfly. Seven Cooley-Tukey layers of 128 butterflies are issued at one
// per cycle. The write-back addresses of in-flight butterflies are held in a
// FIFO. A layer barrier waits for all writes of a layer before the next layer
// reads.
module ntt_layer_scheduler #(
    parameter int DATA_WIDTH = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [7:0]            rd_addr_a,
    output logic [7:0]            rd_addr_b,
    input  logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [DATA_WIDTH-1:0] rd_data_b,
    output logic [6:0]            tw_addr,
    input  logic [DATA_WIDTH-1:0] tw_data,
    output logic                  bf_valid_in,
    output logic [DATA_WIDTH-1:0] bf_a,
    output logic [DATA_WIDTH-1:0] bf_b,
    output logic [DATA_WIDTH-1:0] bf_twiddle,
    input  logic                  bf_valid_out,
    input  logic [DATA_WIDTH-1:0] bf_a_out,
    input  logic [DATA_WIDTH-1:0] bf_b_out,
    output logic                  wr_en,
    output logic [7:0]            wr_addr_a,
    output logic [7:0]            wr_addr_b,
    output logic [DATA_WIDTH-1:0] wr_data_a,
    output logic [DATA_WIDTH-1:0] wr_data_b
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [2:0]       layer;
    logic [6:0]       idx;
    logic [PTR_W-1:0] push_ptr;
    logic [PTR_W-1:0] pop_ptr;
    logic [CNT_W-1:0] outstanding;
    logic [15:0]      fifo_mem [FIFO_DEPTH];

    logic [7:0] len;
    logic [6:0] grp;
    logic [7:0] off;
    logic [7:0] base;
    logic [7:0] addr_a;
    logic [7:0] addr_b;
    logic [6:0] zeta_k;
    logic       push;
    logic       pop;
    logic       fifo_empty;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Cooley-Tukey address and twiddle index for the current (layer, idx)
    always_comb begin
        len    = 8'd128 >> layer;
        grp    = idx >> (3'd7 - layer);
        off    = {1'b0, idx} & (len - 8'd1);
        base   = {1'b0, grp} << (4'd8 - {1'b0, layer});
        addr_a = base + off;
        addr_b = addr_a + len;
        zeta_k = (7'd1 << layer) + grp;
    end

    // Issue whenever a FIFO slot is free; write-back pops only a non-empty FIFO
    always_comb begin
        fifo_empty = (outstanding == '0);
        push       = (state == S_ISSUE) && (outstanding != FULL_CNT);
        pop        = bf_valid_out && !fifo_empty;
    end

    // Output decode: addresses read as zero whenever they are not being used
    always_comb begin
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        rd_en      = push;
        rd_addr_a  = push ? addr_a : 8'd0;
        rd_addr_b  = push ? addr_b : 8'd0;
        tw_addr    = push ? zeta_k : 7'd0;
        bf_a       = rd_data_a;
        bf_b       = rd_data_b;
        bf_twiddle = tw_data;
        wr_en      = bf_valid_out;
        wr_addr_a  = fifo_empty ? 8'd0 : fifo_mem[pop_ptr][15:8];
        wr_addr_b  = fifo_empty ? 8'd0 : fifo_mem[pop_ptr][7:0];
        wr_data_a  = bf_a_out;
        wr_data_b  = bf_b_out;
    end

    // Sequencer: issue a layer, drain it completely, then advance or finish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            layer <= 3'd0;
            idx   <= 7'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_ISSUE;
                        layer <= 3'd0;
                        idx   <= 7'd0;
                    end
                end
                S_ISSUE: begin
                    if (push) begin
                        if (idx == 7'd127) begin
                            state <= S_DRAIN;
                        end else begin
                            idx <= idx + 7'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty) begin
                        if (layer == 3'd6) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_ISSUE;
                            layer <= layer + 3'd1;
                            idx   <= 7'd0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Issue latency into the butterfly: read data arrives one cycle after rd_en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bf_valid_in <= 1'b0;
        end else begin
            bf_valid_in <= push;
        end
    end

    // FIFO control: pointers and occupancy (simultaneous push/pop keeps count)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_ptr    <= '0;
            pop_ptr     <= '0;
            outstanding <= '0;
        end else begin
            if (push) begin
                push_ptr <= ptr_next(push_ptr);
            end
            if (pop) begin
                pop_ptr <= ptr_next(pop_ptr);
            end
            case ({push, pop})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // FIFO storage: write-back address pair captured at issue
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[push_ptr] <= {addr_a, addr_b};
        end
    end

endmodule

// File: tb/tb_ntt_layer_scheduler.sv
// tb_ntt_layer_scheduler
// Two schedulers (FIFO_DEPTH 16 and 4) each drive their own coefficient RAM,
// zeta ROM and 7-stage modular butterfly model. The final memory contents are
// compared with a software Kyber NTT. Read and write addresses are checked
// against a scoreboard queue filled from the reference loop order.
module tb_ntt_layer_scheduler;

    localparam int L = 7;
    localparam int Q = 3329;

    typedef struct {
        int l;
        int i;
        int a;
        int b;
        int k;
    } vec_t;

    logic       clk = 1'b0;
    logic [1:0] rst_s;
    logic [1:0] start_s;
    logic [1:0] busy, done, rd_en, bf_valid_in, bf_valid_out, wr_en;
    logic [7:0]  rd_addr_a [2];
    logic [7:0]  rd_addr_b [2];
    logic [7:0]  wr_addr_a [2];
    logic [7:0]  wr_addr_b [2];
    logic [6:0]  tw_addr   [2];
    logic [11:0] rq_a [2];
    logic [11:0] rq_b [2];
    logic [11:0] rq_z [2];
    logic [11:0] bf_a [2];
    logic [11:0] bf_b [2];
    logic [11:0] bf_z [2];
    logic [11:0] wr_data_a [2];
    logic [11:0] wr_data_b [2];
    logic [L-1:0] pv [2];
    logic [11:0] pa [2][L];
    logic [11:0] pb [2][L];
    logic [11:0] mem [2][256];
    logic [11:0] zetas [128];
    logic [1:0]  load_req;
    int          load_val [2][256];

    int   checks = 0;
    int   errors = 0;
    int   c = 0;
    int   base[2];
    int   depth[2];
    bit   active[2];
    int   nrd[2], nwr[2], busy_cnt[2], done_cnt[2], done_cyc[2];
    int   first_l1[2], last_l0[2], stall_cnt[2], overfill[2];
    int   gold [2][256];
    int   cov [2][7][256];
    logic [22:0] logv [2][896];
    logic [22:0] exp_rd [2][$];
    logic [15:0] exp_wr [2][$];
    vec_t vecs [9];

    always #5 clk = ~clk;

    ntt_layer_scheduler #(.DATA_WIDTH(12), .FIFO_DEPTH(16)) u_dut (
        .clk(clk), .rst_n(rst_s[0]), .start(start_s[0]), .busy(busy[0]), .done(done[0]),
        .rd_en(rd_en[0]), .rd_addr_a(rd_addr_a[0]), .rd_addr_b(rd_addr_b[0]),
        .rd_data_a(rq_a[0]), .rd_data_b(rq_b[0]), .tw_addr(tw_addr[0]), .tw_data(rq_z[0]),
        .bf_valid_in(bf_valid_in[0]), .bf_a(bf_a[0]), .bf_b(bf_b[0]), .bf_twiddle(bf_z[0]),
        .bf_valid_out(bf_valid_out[0]), .bf_a_out(pa[0][L-1]), .bf_b_out(pb[0][L-1]),
        .wr_en(wr_en[0]), .wr_addr_a(wr_addr_a[0]), .wr_addr_b(wr_addr_b[0]),
        .wr_data_a(wr_data_a[0]), .wr_data_b(wr_data_b[0])
    );

    ntt_layer_scheduler #(.DATA_WIDTH(12), .FIFO_DEPTH(4)) u_small (
        .clk(clk), .rst_n(rst_s[1]), .start(start_s[1]), .busy(busy[1]), .done(done[1]),
        .rd_en(rd_en[1]), .rd_addr_a(rd_addr_a[1]), .rd_addr_b(rd_addr_b[1]),
        .rd_data_a(rq_a[1]), .rd_data_b(rq_b[1]), .tw_addr(tw_addr[1]), .tw_data(rq_z[1]),
        .bf_valid_in(bf_valid_in[1]), .bf_a(bf_a[1]), .bf_b(bf_b[1]), .bf_twiddle(bf_z[1]),
        .bf_valid_out(bf_valid_out[1]), .bf_a_out(pa[1][L-1]), .bf_b_out(pb[1][L-1]),
        .wr_en(wr_en[1]), .wr_addr_a(wr_addr_a[1]), .wr_addr_b(wr_addr_b[1]),
        .wr_data_a(wr_data_a[1]), .wr_data_b(wr_data_b[1])
    );

    assign bf_valid_out = {pv[1][L-1], pv[0][L-1]};

    function automatic logic [11:0] bfly_a(input logic [11:0] a, input logic [11:0] b, input logic [11:0] z);
        int t;
        t = (int'(z) * int'(b)) % Q;
        return 12'((int'(a) + t) % Q);
    endfunction

    function automatic logic [11:0] bfly_b(input logic [11:0] a, input logic [11:0] b, input logic [11:0] z);
        int t;
        t = (int'(z) * int'(b)) % Q;
        return 12'((int'(a) - t + Q) % Q);
    endfunction

    // Memory, zeta ROM and butterfly pipeline models for both instances
    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (load_req[n]) begin
                for (int i = 0; i < 256; i++) mem[n][i] <= 12'(load_val[n][i]);
            end else if (wr_en[n]) begin
                mem[n][wr_addr_a[n]] <= wr_data_a[n];
                mem[n][wr_addr_b[n]] <= wr_data_b[n];
            end
            if (rd_en[n]) begin
                rq_a[n] <= mem[n][rd_addr_a[n]];
                rq_b[n] <= mem[n][rd_addr_b[n]];
                rq_z[n] <= zetas[tw_addr[n]];
            end
            if (!rst_s[n]) pv[n] <= '0;
            else           pv[n] <= {pv[n][L-2:0], bf_valid_in[n]};
            pa[n][0] <= bfly_a(bf_a[n], bf_b[n], bf_z[n]);
            pb[n][0] <= bfly_b(bf_a[n], bf_b[n], bf_z[n]);
            for (int s = 1; s < L; s++) begin
                pa[n][s] <= pa[n][s-1];
                pb[n][s] <= pb[n][s-1];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, c);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, c);
    endtask

    function automatic int bitrev7(input int x);
        int r = 0;
        for (int b = 0; b < 7; b++) if (x[b]) r |= 1 << (6 - b);
        return r;
    endfunction

    // Load (optional), compute golden NTT in place and queue expected addresses
    task automatic begin_run(input int n, input bit load);
        int k, z, t, x;
        if (load) begin
            for (int i = 0; i < 256; i++) begin
                gold[n][i]     = int'($urandom_range(0, Q - 1));
                load_val[n][i] = gold[n][i];
            end
            load_req[n] = 1'b1;
        end
        exp_rd[n].delete();
        exp_wr[n].delete();
        k = 1;
        for (int len = 128; len >= 2; len = len >> 1) begin
            for (int s = 0; s < 256; s += 2 * len) begin
                z = int'(zetas[k]);
                for (int j = s; j < s + len; j++) begin
                    t = (z * gold[n][j + len]) % Q;
                    x = gold[n][j];
                    gold[n][j + len] = (x - t + Q) % Q;
                    gold[n][j]       = (x + t) % Q;
                    exp_rd[n].push_back({8'(j), 8'(j + len), 7'(k)});
                    exp_wr[n].push_back({8'(j), 8'(j + len)});
                end
                k++;
            end
        end
        for (int l = 0; l < 7; l++) for (int a = 0; a < 256; a++) cov[n][l][a] = 0;
        nrd[n] = 0; nwr[n] = 0; busy_cnt[n] = 0; done_cnt[n] = 0; done_cyc[n] = -1;
        first_l1[n] = -1; last_l0[n] = -1; stall_cnt[n] = 0; overfill[n] = 0;
        base[n] = c;
        active[n] = 1'b1;
    endtask

    // Per-cycle monitor and scoreboard for one instance
    task automatic observe(input int n);
        int cy, occ;
        logic [22:0] got;
        logic [15:0] gw;
        if (!active[n]) return;
        cy  = c - base[n];
        occ = nrd[n] - nwr[n];
        if (busy[n]) busy_cnt[n]++;
        if (done[n]) begin
            done_cnt[n]++;
            done_cyc[n] = cy;
        end
        if (busy[n] && !rd_en[n] && occ == depth[n] && nrd[n] < 896) stall_cnt[n]++;
        if (rd_en[n]) begin
            got = {rd_addr_a[n], rd_addr_b[n], tw_addr[n]};
            if (occ >= depth[n]) overfill[n]++;
            if (exp_rd[n].size() == 0) fail("rd_unexpected");
            else chk("rd_addr_abk", got, exp_rd[n].pop_front());
            if (nrd[n] < 896) begin
                logv[n][nrd[n]] = got;
                cov[n][nrd[n] / 128][rd_addr_a[n]]++;
                cov[n][nrd[n] / 128][rd_addr_b[n]]++;
            end
            if (nrd[n] == 128) first_l1[n] = cy;
            nrd[n]++;
        end
        if (wr_en[n]) begin
            gw = {wr_addr_a[n], wr_addr_b[n]};
            if (exp_wr[n].size() == 0) fail("wr_unexpected");
            else chk("wr_addr_ab", gw, exp_wr[n].pop_front());
            if (nwr[n] == 127) last_l0[n] = cy;
            nwr[n]++;
        end
    endtask

    // End-of-transform checks common to both instances
    task automatic result_checks(input int n);
        int bad, ok;
        bad = 0;
        ok = 0;
        for (int i = 0; i < 256; i++) if (int'(mem[n][i]) != gold[n][i]) bad++;
        chk("mem_vs_golden", bad, 0);
        chk("read_count", nrd[n], 896);
        chk("write_count", nwr[n], 896);
        chk("done_pulses", done_cnt[n], 1);
        for (int l = 0; l < 7; l++) for (int a = 0; a < 256; a++) if (cov[n][l][a] == 1) ok++;
        chk("addr_once_per_layer", ok, 7 * 256);
        chk("fifo_overfill", overfill[n], 0);
        for (int v = 0; v < 9; v++) begin
            chk("vec_addr", logv[n][vecs[v].l * 128 + vecs[v].i],
                {8'(vecs[v].a), 8'(vecs[v].b), 7'(vecs[v].k)});
        end
    endtask

    task automatic timing_checks(input int n);
        chk("done_cycle", done_cyc[n], 960);
        chk("busy_cycles", busy_cnt[n], 960);
        chk("first_l1_read", first_l1[n], 138);
        chk("last_l0_write", last_l0[n], 136);
    endtask

    initial begin
        int ph0, ph1, cy;
        int z;
        vecs[0] = '{0,   0,   0, 128,   1};
        vecs[1] = '{0, 127, 127, 255,   1};
        vecs[2] = '{1,   0,   0,  64,   2};
        vecs[3] = '{1,  64, 128, 192,   3};
        vecs[4] = '{2,  33,  65,  97,   5};
        vecs[5] = '{3, 100, 196, 212,  14};
        vecs[6] = '{5,  77, 153, 157,  51};
        vecs[7] = '{6,   0,   0,   2,  64};
        vecs[8] = '{6, 127, 253, 255, 127};
        for (int k = 0; k < 128; k++) begin
            z = 1;
            for (int e = 0; e < bitrev7(k); e++) z = (z * 17) % Q;
            zetas[k] = 12'(z);
        end
        depth[0] = 16;
        depth[1] = 4;
        active[0] = 1'b0;
        active[1] = 1'b0;
        rst_s = 2'b00;
        start_s = 2'b00;
        load_req = 2'b00;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 2'b00);
        chk("rst_done", done, 2'b00);
        chk("rst_rd_en", rd_en, 2'b00);
        chk("rst_bf_valid_in", bf_valid_in, 2'b00);
        chk("rst_addrs", {rd_addr_a[0], rd_addr_b[0], tw_addr[0], wr_addr_a[0], wr_addr_b[0]}, 0);
        chk("rst_wr_en", wr_en, 2'b00);
        @(negedge clk);
        rst_s = 2'b11;
        @(negedge clk);

        c = 0;
        begin_run(0, 1'b1);
        begin_run(1, 1'b1);
        start_s = 2'b11;
        ph0 = 1;
        ph1 = 1;
        for (c = 1; c <= 3000; c++) begin
            @(negedge clk);
            load_req = 2'b00;
            observe(0);
            observe(1);
            start_s = 2'b00;
            cy = c - base[0];
            case (ph0)
                1: begin
                    if (cy == 50 || cy == 960) start_s[0] = 1'b1;
                    if (cy == 961) begin
                        timing_checks(0);
                        result_checks(0);
                        begin_run(0, 1'b0);
                        start_s[0] = 1'b1;
                        ph0 = 2;
                    end
                end
                2: begin
                    if (cy == 400) begin
                        rst_s[0] = 1'b0;
                        active[0] = 1'b0;
                        #1;
                        chk("arst_busy", busy[0], 1'b0);
                        chk("arst_done", done[0], 1'b0);
                        chk("arst_rd_en", rd_en[0], 1'b0);
                        chk("arst_bf_valid_in", bf_valid_in[0], 1'b0);
                        chk("arst_rd_addrs", {rd_addr_a[0], rd_addr_b[0], tw_addr[0]}, 0);
                        exp_rd[0].delete();
                        exp_wr[0].delete();
                    end
                    if (cy == 401) chk("arst_fifo_empty", {wr_addr_a[0], wr_addr_b[0]}, 0);
                    if (cy == 402) rst_s[0] = 1'b1;
                    if (cy == 403) chk("idle_after_rst", {busy[0], rd_en[0]}, 2'b00);
                    if (cy == 404) begin
                        begin_run(0, 1'b1);
                        start_s[0] = 1'b1;
                        ph0 = 3;
                    end
                end
                3: begin
                    if (cy == 962) begin
                        timing_checks(0);
                        result_checks(0);
                        ph0 = 4;
                    end
                end
                default: ;
            endcase
            if (ph1 == 1 && done_cnt[1] > 0 && (c - base[1]) == done_cyc[1] + 1) begin
                result_checks(1);
                chk("small_fifo_stalls", stall_cnt[1] > 0, 1'b1);
                ph1 = 2;
            end
            if (ph0 == 4 && ph1 == 2) break;
        end
        if (ph0 != 4) fail("timeout_main_instance");
        if (ph1 != 2) fail("timeout_small_fifo_instance");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
